// File: rtl/alu_control_md_if.sv
// Bundle of decode inputs, multiply/divide operands and the HI/LO result outputs
// shared between the control unit (master) and alu_control_md (slave).
interface alu_control_md_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             valid_in;
    logic [2:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [OPW-1:0]   operation;
    logic             Jr;
    logic             illegal;
    logic             stall;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, ALUOp, funct, rs_val, rt_val,
        input  operation, Jr, illegal, stall, md_busy, md_done, hi, lo
    );

    modport slave (
        input  valid_in, ALUOp, funct, rs_val, rt_val,
        output operation, Jr, illegal, stall, md_busy, md_done, hi, lo
    );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle) writing the HI/LO registers.
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_control_md_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    state_t state, state_nx;

    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic                 is_div, dz, neg_q, neg_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 md_busy_r, md_done_r;

    logic [3:0]           op4;
    logic                 jr, ill, md_op, hl_op;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic s);
        mag = (s && v < 0) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
        cneg = n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
        cneg2 = n ? -v : v;
    endfunction

    always_comb begin
        op4   = 4'b0010;
        jr    = 1'b0;
        ill   = 1'b0;
        md_op = 1'b0;
        hl_op = 1'b0;
        case (bus.ALUOp)
            3'b000: op4 = 4'b0010;
            3'b001: op4 = 4'b0110;
            3'b100: op4 = 4'b0000;
            3'b101: op4 = 4'b0001;
            3'b010: begin
                case (bus.funct)
                    6'b100000: op4 = 4'b0010;
                    6'b100010: op4 = 4'b0110;
                    6'b100100: op4 = 4'b0000;
                    6'b100101: op4 = 4'b0001;
                    6'b101010: op4 = 4'b0111;
                    6'b000000: op4 = 4'b0101;
                    6'b100111: op4 = 4'b1011;
                    6'b001000: begin op4 = 4'b0010; jr = 1'b1; end
                    6'b010000: begin op4 = 4'b1100; hl_op = 1'b1; end
                    6'b010010: begin op4 = 4'b1101; hl_op = 1'b1; end
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: begin op4 = 4'b0010; md_op = 1'b1; end
                    default: begin op4 = 4'b1111; ill = 1'b1; end
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

    // funct[1] separates div/divu from mult/multu; funct[0] marks the unsigned forms
    logic             sgn, dz_in, accept;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    assign sgn    = ~bus.funct[0];
    assign dz_in  = bus.funct[1] && (bus.rt_val == '0);
    assign rs_mag = mag(bus.rs_val, sgn);
    assign rt_mag = mag(bus.rt_val, sgn);
    assign accept = bus.valid_in && (state == IDLE) && md_op;

    // md_done covers the HI/LO read hazard in the cycle the results land
    assign bus.operation = OPW'(op4);
    assign bus.Jr        = jr;
    assign bus.illegal   = ill;
    assign bus.stall     = rst_n && bus.valid_in &&
                           ((md_busy_r && (md_op || hl_op)) || (md_done_r && hl_op));
    assign bus.md_busy   = md_busy_r;
    assign bus.md_done   = md_done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = dz_in ? FIN : (bus.funct[1] ? DIV : MUL);
            MUL, DIV: if (cnt == CW'(WIDTH - 1)) state_nx = FIN;
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            md_busy_r <= 1'b0;
            md_done_r <= 1'b0;
        end else begin
            state     <= state_nx;
            md_busy_r <= (state_nx != IDLE);
            md_done_r <= (state == FIN);
        end
    end

    // acc holds the running product, or {partial remainder, quotient/dividend bits}
    logic [WIDTH:0]       mul_sum, div_sh, div_df;
    logic [2*WIDTH-1:0]   mul_nx, div_nx;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, opnd};
    assign div_nx  = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    is_div <= bus.funct[1];
                    dz     <= dz_in;
                    neg_q  <= sgn && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                    neg_r  <= sgn && bus.rs_val[WIDTH-1];
                    if (bus.funct[1]) begin
                        opnd <= rt_mag;
                        acc  <= {{WIDTH{1'b0}}, (dz_in ? bus.rs_val : rs_mag)};
                    end else begin
                        opnd <= rs_mag;
                        acc  <= {{WIDTH{1'b0}}, rt_mag};
                    end
                end
                MUL: begin
                    acc <= mul_nx;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_nx;
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    if (dz) begin
                        hi_r <= acc[WIDTH-1:0];
                        lo_r <= '1;
                    end else if (is_div) begin
                        hi_r <= cneg(acc[2*WIDTH-1:WIDTH], neg_r);
                        lo_r <= cneg(acc[WIDTH-1:0], neg_q);
                    end else begin
                        {hi_r, lo_r} <= cneg2(acc, neg_q);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode tables, directed and random multiply/divide
// against an integer-arithmetic reference, HI/LO read stall and mid-operation reset.
module tb_alu_control_md;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIVS = 6'b011010, DIVU = 6'b011011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_control_md_if #(.WIDTH(W), .OPW(4)) bus ();
    alu_control_md #(.WIDTH(W), .OPW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] aop_op  [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0010};
    bit         aop_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] rop [logic [5:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa = longint'(signed'(a));
        longint sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [2*W-1:0] p;
        h = '0; l = '0;
        case (f)
            MULT:  begin p = sa * sb; {h, l} = p; end
            MULTU: begin p = ua * ub; {h, l} = p; end
            DIVS:  if (b == 0) begin h = a; l = '1; end
                   else begin l = W'(sa / sb); h = W'(sa % sb); end
            default: if (b == 0) begin h = a; l = '1; end
                     else begin l = W'(ua / ub); h = W'(ua % ub); end
        endcase
    endfunction

    task automatic wait_done(input string tag, input int exp_lat, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input logic [W-1:0] ph, input logic [W-1:0] pl);
        int n = 1;
        bit hold_ok = 1'b1;
        while (bus.md_done !== 1'b1 && n < W + 10) begin
            if (bus.hi !== ph || bus.lo !== pl) hold_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ":latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ":hold"}, 64'(hold_ok), 64'd1);
        chk({tag, ":hi"}, bus.hi, eh);
        chk({tag, ":lo"}, bus.lo, el);
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el, ph, pl;
        ref_md(f, a, b, eh, el);
        ph = bus.hi; pl = bus.lo;
        bus.valid_in = 1'b1; bus.ALUOp = 3'b010; bus.funct = f; bus.rs_val = a; bus.rt_val = b;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk({tag, ":busy"}, 64'(bus.md_busy), 64'd1);
        wait_done(tag, (f[1] && b == 0) ? 2 : W + 2, eh, el, ph, pl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] eh, el, ph, pl, a, b;
        logic [5:0]   f;
        logic [3:0]   eop;
        bit           eill;
        logic [5:0]   fcodes [4] = '{MULT, MULTU, DIVS, DIVU};

        rop[6'b100000] = 4'b0010; rop[6'b100010] = 4'b0110; rop[6'b100100] = 4'b0000;
        rop[6'b100101] = 4'b0001; rop[6'b101010] = 4'b0111; rop[6'b000000] = 4'b0101;
        rop[6'b100111] = 4'b1011; rop[6'b001000] = 4'b0010; rop[6'b010000] = 4'b1100;
        rop[6'b010010] = 4'b1101; rop[MULT] = 4'b0010; rop[MULTU] = 4'b0010;
        rop[DIVS] = 4'b0010; rop[DIVU] = 4'b0010;

        // Reset: registered outputs clear, decode still follows inputs, no stall
        rst_n = 1'b0;
        bus.valid_in = 1'b1; bus.ALUOp = 3'b010; bus.funct = MULT;
        bus.rs_val = 32'd7; bus.rt_val = 32'd9;
        #1;
        chk("rst:busy", 64'(bus.md_busy), 64'd0);
        chk("rst:done", 64'(bus.md_done), 64'd0);
        chk("rst:hi", bus.hi, 64'd0);
        chk("rst:lo", bus.lo, 64'd0);
        chk("rst:stall", 64'(bus.stall), 64'd0);
        chk("rst:op", bus.operation, 64'h2);
        bus.valid_in = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int aop = 0; aop < 8; aop++) begin
            bus.ALUOp = 3'(aop);
            bus.funct = (aop == 2) ? 6'b100000 : 6'($urandom);
            #1;
            eop  = (aop == 2) ? 4'b0010 : aop_op[aop];
            eill = aop_ill[aop];
            chk($sformatf("aop%0d:op", aop), bus.operation, eop);
            chk($sformatf("aop%0d:ill", aop), 64'(bus.illegal), 64'(eill));
            chk($sformatf("aop%0d:jr", aop), 64'(bus.Jr), 64'd0);
        end
        bus.ALUOp = 3'b010;
        for (int fi = 0; fi < 64; fi++) begin
            f = 6'(fi);
            bus.funct = f;
            #1;
            eop  = rop.exists(f) ? rop[f] : 4'b1111;
            eill = !rop.exists(f);
            chk($sformatf("funct%02h:op", f), bus.operation, eop);
            chk($sformatf("funct%02h:ill", f), 64'(bus.illegal), 64'(eill));
            chk($sformatf("funct%02h:jr", f), 64'(bus.Jr), 64'(f == 6'b001000));
        end
        @(posedge clk); #1;

        run_md("mult_m3x5", MULT, -32'sd3, 32'd5);
        chk("mult_m3x5:hi_const", bus.hi, 64'hFFFFFFFF);
        chk("mult_m3x5:lo_const", bus.lo, 64'hFFFFFFF1);
        run_md("divu_100_7", DIVU, 32'd100, 32'd7);
        chk("divu_100_7:lo_const", bus.lo, 64'h0000000E);
        chk("divu_100_7:hi_const", bus.hi, 64'h00000002);
        run_md("div_m7_2", DIVS, -32'sd7, 32'd2);
        chk("div_m7_2:lo_const", bus.lo, 64'hFFFFFFFD);
        chk("div_m7_2:hi_const", bus.hi, 64'hFFFFFFFF);
        run_md("div_by0", DIVS, 32'h1234, 32'd0);
        chk("div_by0:lo_const", bus.lo, 64'hFFFFFFFF);
        chk("div_by0:hi_const", bus.hi, 64'h00001234);
        run_md("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md("div_min_m1", DIVS, 32'h80000000, 32'hFFFFFFFF);
        run_md("divu_by0", DIVU, 32'hDEADBEEF, 32'd0);

        for (int i = 0; i < 16; i++) begin
            f = fcodes[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = b % 32'd37;
            if ($urandom_range(0, 5) == 0) b = '0;
            run_md($sformatf("rnd%0d_f%02h", i, f), f, a, b);
        end

        // mfhi presented while a multiply is in flight
        a = $urandom; b = $urandom;
        ref_md(MULT, a, b, eh, el);
        bus.valid_in = 1'b1; bus.ALUOp = 3'b010; bus.funct = MULT; bus.rs_val = a; bus.rt_val = b;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.valid_in = 1'b1; bus.funct = 6'b010000;
        #1;
        for (int e = 4; e <= W + 3; e++) begin
            if (e > 4) begin @(posedge clk); #1; end
            chk($sformatf("mfhi_stall_e%0d", e), 64'(bus.stall), 64'(e <= W + 2));
            if (e == W + 2) chk("mfhi:done", 64'(bus.md_done), 64'd1);
        end
        chk("mfhi:op", bus.operation, 64'hC);
        chk("mfhi:hi", bus.hi, eh);
        chk("mfhi:lo", bus.lo, el);
        bus.valid_in = 1'b0;

        // Reset ten cycles into a multiply, then a fresh multiply right after release
        bus.valid_in = 1'b1; bus.funct = MULT; bus.rs_val = $urandom; bus.rt_val = $urandom;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        a = $urandom; b = $urandom;
        ref_md(MULT, a, b, eh, el);
        bus.rs_val = a; bus.rt_val = b;
        rst_n = 1'b0;
        #1;
        chk("abort:busy", 64'(bus.md_busy), 64'd0);
        chk("abort:done", 64'(bus.md_done), 64'd0);
        chk("abort:hi", bus.hi, 64'd0);
        chk("abort:lo", bus.lo, 64'd0);
        chk("abort:stall", 64'(bus.stall), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk("restart:busy", 64'(bus.md_busy), 64'd1);
        ph = '0; pl = '0;
        wait_done("restart", W + 2, eh, el, ph, pl);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_control_md.md
ALU_CONTROL_MD -- requirements
Module: alu_control_md

Interface
REQ-001 Parameter WIDTH, default 32, sets the datapath width of operands, HI and LO; it SHALL be legal for any even value from 8 to 64.
REQ-002 Parameter OPW, default 4, sets the width of operation; it SHALL be at least 4.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 valid_in  in  1  instruction fields are valid this cycle.
REQ-006 ALUOp  in  3  operation class from the control unit.
REQ-007 funct  in  6  Instruction[5:0].
REQ-008 rs_val, rt_val  in  WIDTH  register operands for multiply and divide.
REQ-009 operation  out  OPW  ALU operation select; combinational.
REQ-010 Jr  out  1  jump-register control; combinational.
REQ-011 illegal  out  1  unknown funct under R-format; combinational.
REQ-012 stall  out  1  pipeline must hold the current instruction; combinational.
REQ-013 md_busy  out  1  multiply/divide engine is active; registered.
REQ-014 md_done  out  1  one-cycle pulse when HI/LO are written; registered.
REQ-015 hi, lo  out  WIDTH  HI/LO architectural registers.

Function
REQ-016 ALUOp SHALL be decoded by exact 3-bit match with no priority overlap: 000 gives 0010; 001 gives 0110; 100 gives 0000 (andi); 101 gives 0001 (ori); 010 selects R-format; any other value gives 0010 with illegal=1.
REQ-017 The R-format funct map SHALL be:
- 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001
- 101010 → 0111; 000000 → 0101 (sll); 100111 → 1011
- 001000 → 0010 with Jr=1
- 010000 (mfhi) → 1100; 010010 (mflo) → 1101
- 011000 mult, 011001 multu, 011010 div, 011011 divu → 0010
- any other funct → 1111 with illegal=1
REQ-018 Jr SHALL be 0 for every case other than R-format jr.
REQ-019 The FSM states SHALL be IDLE, MUL, DIV and FIN.
REQ-020 A multiply or divide is accepted when valid_in=1 and the state is IDLE; operands are latched on that edge, with magnitudes taken for the signed ops.
REQ-021 After acceptance the FSM SHALL go to MUL or DIV and perform a shift-add or restoring-subtract step each cycle for exactly WIDTH cycles, then go to FIN.
REQ-022 FIN SHALL apply the sign fix-up, write hi/lo, pulse md_done and return to IDLE.
REQ-023 Latency SHALL be WIDTH+2 edges from acceptance to hi/lo valid.
REQ-024 Multiply results SHALL be hi:lo = the 2*WIDTH-bit product.
REQ-025 Divide results SHALL be lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-026 Divide by zero SHALL skip DIV, go straight to FIN, and set lo = all ones and hi = dividend; latency 2 edges.
REQ-027 md_busy SHALL be 1 in MUL, DIV and FIN, and 0 otherwise.
REQ-028 stall SHALL be valid_in AND md_busy AND (funct is mfhi, mflo, mult, multu, div or divu) AND ALUOp=010.
REQ-029 A stalled instruction SHALL NOT be accepted; it is accepted on the first cycle with md_busy=0.
REQ-030 hi and lo SHALL hold their value except at FIN.
REQ-031 When md_done=1 and mfhi or mflo is presented in the same cycle, stall SHALL be 1 and the read occurs the following cycle.

Reset
REQ-032 When rst_n=0, the block SHALL immediately set state=IDLE, hi=0, lo=0, md_busy=0 and md_done=0, and clear the internal accumulators.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no hi/lo update and no md_done pulse.
REQ-034 Combinational outputs SHALL follow their inputs during reset, and stall SHALL be 0 during reset.

Verification
REQ-035 ALUOp=101 → operation=0001, Jr=0; ALUOp=010 with funct=001000 → operation=0010, Jr=1; ALUOp=010 with funct=111111 → operation=1111, illegal=1.
REQ-036 WIDTH=32, mult with rs=-3 and rt=5 → md_done exactly 34 edges after acceptance, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-037 divu 100/7 → lo=0000000E, hi=00000002; div -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
REQ-038 div with rt=0 and rs=0x1234 → md_done after 2 edges, lo=FFFFFFFF, hi=00001234.
REQ-039 mfhi issued 3 cycles after a mult → stall=1 until the cycle after md_done, then operation=1100 and stall=0.
REQ-040 rst_n pulsed low 10 cycles into a multiply → md_busy=0 and hi=lo=0 at once, no md_done pulse, and a new multiply is accepted in the first cycle after release.
